// File: rtl/fft_out_reorder.sv
// fft_out_reorder: two-bank ping-pong frame buffer behind the FFT core; when
// FFT_OUT_REORDER_BITREV_EN is defined the write address is bit-reversed to restore natural order.
module fft_out_reorder #(
  parameter int DATA_W = 32,
  parameter int LOG2N = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  output logic [7:0]        frames_done
);
  localparam int N = 1 << LOG2N;
  logic [DATA_W-1:0] mem [2][N];
  logic [1:0] full, set_m, clr_m;
  logic wr_bank, rd_bank, wr_en, wr_done, rd_fire, rd_done;
  logic [LOG2N-1:0] wr_cnt, rd_cnt, waddr;
`ifdef FFT_OUT_REORDER_BITREV_EN
  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign waddr[i] = wr_cnt[LOG2N-1-i];
  end
`else
  assign waddr = wr_cnt;
`endif
  assign wr_en = in_valid && !full[wr_bank];
  assign wr_done = wr_en && &wr_cnt;
  assign out_valid = full[rd_bank];
  assign out_data = mem[rd_bank][rd_cnt];
  assign out_last = out_valid && &rd_cnt;
  assign rd_fire = out_valid && out_ready;
  assign rd_done = rd_fire && &rd_cnt;
  // completing one bank and freeing the other can coincide; both masks apply
  assign set_m = wr_done ? 2'b01 << wr_bank : 2'b00;
  assign clr_m = rd_done ? 2'b01 << rd_bank : 2'b00;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_bank][waddr] <= in_data;
  always_ff @(posedge clk)
    if (rst) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      overflow <= 1'b0;
      frames_done <= '0;
    end else begin
      full <= (full | set_m) & ~clr_m;
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (in_valid && full[wr_bank]) overflow <= 1'b1;
      if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
        frames_done <= frames_done + 8'd1;
      end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed self-checking bench for fft_out_reorder.
module tb_fft_out_reorder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] out_data;
  logic out_valid, out_last, overflow;
  logic [7:0] frames_done;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] got[$];
  logic last_q[$];
  int cyc_q[$];
  fft_out_reorder #(.DATA_W(32), .LOG2N(6)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .frames_done(frames_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rev(input int k);
    logic [31:0] r;
    r = k;
`ifdef FFT_OUT_REORDER_BITREV_EN
    r = '0;
    for (int j = 0; j < 6; j++) r[j] = k[5-j];
`endif
    return r;
  endfunction
  // accepted beats are logged, and a stalled word must not change until taken
  initial begin
    logic hold;
    logic [31:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else begin
        if (hold && out_valid) check("hold", out_data, held);
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          last_q.push_back(out_last);
          cyc_q.push_back(cyc);
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    got.delete();
    last_q.delete();
    cyc_q.delete();
  endtask
  task automatic feed(input int base, input int count, input bit chk_lat);
    for (int i = 0; i < count; i++) begin
      in_data = base + i;
      in_valid = 1'b1;
      if (chk_lat && i == count - 1) check("lat_pre", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
  endtask
  task automatic drain(input int bound);
    for (int i = 0; i < bound && out_valid; i++) step();
    check("drain_idle", out_valid, 0);
  endtask
  task automatic check_out(input string tag, input int n, input int b0, input int b1);
    check({tag, "_count"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++) begin
      check({tag, "_data"}, got[k], (k < 64 ? b0 : b1) + rev(k % 64));
      check({tag, "_last"}, last_q[k], k % 64 == 63);
    end
  endtask
  initial begin
    int maxgap;
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_frames", frames_done, 0);
    // single frame, latency and order
    out_ready = 1'b1;
    feed(0, 64, 1);
    check("lat", out_valid, 1);
    check("first_word", out_data, rev(0));
    drain(100);
    check_out("f1", 64, 0, 0);
    check("f1_frames", frames_done, 1);
    // back-to-back frames with no output bubble
    do_reset();
    out_ready = 1'b1;
    feed(0, 64, 0);
    feed(100, 64, 0);
    drain(100);
    check_out("b2b", 128, 0, 100);
    maxgap = 0;
    for (int k = 1; k < cyc_q.size(); k++)
      if (cyc_q[k] - cyc_q[k-1] > maxgap) maxgap = cyc_q[k] - cyc_q[k-1];
    check("b2b_gap", maxgap, 1);
    check("b2b_frames", frames_done, 2);
    check("b2b_ovf", overflow, 0);
    // consumer stalled: third frame dropped
    do_reset();
    out_ready = 1'b0;
    feed(0, 128, 0);
    check("ovf_before", overflow, 0);
    check("ovf_full_valid", out_valid, 1);
    feed(128, 64, 0);
    check("ovf_after", overflow, 1);
    check("ovf_frames0", frames_done, 0);
    out_ready = 1'b1;
    drain(200);
    check_out("ovf", 128, 0, 64);
    check("ovf_frames", frames_done, 2);
    // ready toggling every cycle during drain
    do_reset();
    out_ready = 1'b0;
    feed(200, 64, 0);
    for (int i = 0; i < 200 && out_valid; i++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    check("tog_idle", out_valid, 0);
    check_out("tog", 64, 200, 0);
    // reset in the middle of a frame
    do_reset();
    out_ready = 1'b1;
    feed(900, 20, 0);
    do_reset();
    feed(500, 64, 0);
    drain(100);
    check_out("mid_rst", 64, 500, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_frames", frames_done, 1);
    // frame counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 255; f++) feed(f, 64, 0);
    drain(100);
    check("wrap_255", frames_done, 255);
    feed(7, 64, 0);
    drain(100);
    check("wrap_0", frames_done, 0);
    check("wrap_ovf", overflow, 0);
    check("wrap_count", got.size(), 256 * 64);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer that sits directly downstream of the 64-point FFT core. It captures each 64-word result frame (32-bit complex words, {re[15:0], im[15:0]}) as the core streams it out. It restores natural frequency order by bit-reversing the write address, then drains the frame to a valid/ready consumer. A two-bank ping-pong store lets frame N+1 be captured while frame N drains.

## Interface
Parameters:
- DATA_W, 32, word width
- LOG2N, 6, log2 of frame length (N = 64)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  DATA_W  FFT result word
- in_valid  input  1  word valid (FFT core output-valid strobe)
- out_data  output  DATA_W  reordered word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts word
- out_last  output  1  high with word index N-1 of a frame
- overflow  output  1  sticky: an input word was dropped
- frames_done  output  8  count of fully drained frames, wraps 255→0

## Operation
- Storage: bank[0..1][0..N-1] of DATA_W; per-bank full flag.
- Write side: wr_bank (init 0) and wr_cnt (LOG2N bits, init 0).
  - in_valid && !full[wr_bank]: write in_data to bank[wr_bank][addr(wr_cnt)], wr_cnt++.
  - On the write with wr_cnt == N-1: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
  - in_valid && full[wr_bank]: word dropped, wr_cnt unchanged, overflow set until rst.
- Read side: rd_bank (init 0) and rd_cnt (init 0).
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_cnt] (combinational read of registered array).
  - out_last = out_valid && rd_cnt == N-1.
  - out_valid && out_ready: rd_cnt++.
  - Handshake with rd_cnt == N-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0, frames_done++.
- Simultaneous set (write side completes bank A) and clear (read side frees bank B) in one cycle: both take effect.
- Bank A == B cannot occur.
- Write into the bank just freed is allowed from the next cycle.
- States are implicit: per-bank EMPTY → FILLING → FULL → DRAINING → EMPTY. The implementation may use an explicit FSM per bank with the same externally visible behaviour.
- out_data must hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_last 0, overflow 0, frames_done 0, all full flags 0, wr_bank/rd_bank/wr_cnt/rd_cnt 0. out_data is don't-care while out_valid is 0.
- rst mid-frame: partial frames in both banks are discarded. The next in_valid is treated as word 0 of bank 0.
- Latency: the 64th input word is written at edge T, and out_valid is 1 in the cycle after T. The first output word is available in that cycle.
- Throughput: 1 word/cycle on each side. Continuous in_valid with out_ready held 1 never overflows.
- Back-to-back frames: a gap-free input stream switches banks with no bubble on the write side.
- out_valid stays high across the frame boundary if the other bank is already full (no bubble).

## Configuration
- FFT_OUT_REORDER_BITREV_EN defined: addr(i) = bit-reverse of i over LOG2N bits (e.g. i=1 → 32, i=6 → 24). Output is in natural order.
- Not defined: addr(i) = i. The block is a pure ping-pong frame buffer and output order equals input order.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset, then in_valid for 64 cycles with in_data = i at input index i, out_ready=1 → out_valid rises the cycle after the 64th word. With BITREV_EN, the outputs are 0,32,16,48,8,…,63 (bit-reverse of k); without the macro they are 0..63. out_last is only on the 64th output beat, and frames_done = 1.
- Two frames back-to-back (values 0..63, then 100..163), out_ready=1 → 128 output beats with no out_valid gap between frames; frames_done = 2; overflow = 0.
- out_ready=0 throughout, three frames input → first two frames stored, first word of third frame dropped, overflow=1. After out_ready goes to 1, exactly 128 words drain, then out_valid=0.
- out_ready toggled 1/0 every cycle during drain → each word held stable while stalled; 64 unique words, no duplicates or skips.
- rst asserted after 20 words of a frame, then a fresh 64-word frame → only the fresh frame is output, overflow=0, frames_done=1.
- 255 frames followed by one more → frames_done wraps to 0.
